// File: rtl/fetch_if_id.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, registers each fetched
// instruction together with its PC, honours hazard-unit holds, redirects on
// decode-stage branches, stops on a HALT opcode and keeps fetch/stall counters.
module fetch_if_id #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter logic [3:0]         HALT_OP   = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold_pc,
  input  logic               hold_if_id,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic               halted,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic               valid_q, valid_d;
  logic [31:0]        fetch_cnt_q, fetch_cnt_d;
  logic [31:0]        stall_cnt_q, stall_cnt_d;

  logic               pc_hold;
  logic [3:0]         fetch_op;

  // An IF/ID hold always stalls the PC too, so nothing is lost in the hold.
  assign pc_hold  = hold_pc | hold_if_id;
  assign fetch_op = imem_data[INSTR_W-1 -: 4];

  // Next-state logic: priority is IF/ID hold, branch, PC-only hold, fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      StBoot: begin
        // One idle cycle after reset release; IF/ID keeps its reset bubble.
        state_d = StRun;
      end

      StRun: begin
        if (pc_hold) begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end

        if (hold_if_id) begin
          // Branch in decode is held and will present again; ignore it now.
        end else if (branch_taken) begin
          // Squash the wrong-path fetch sitting on imem_data this cycle.
          pc_d    = branch_target;
          instr_d = NOP_INSTR;
          ipc_d   = pc_q;
          valid_d = 1'b0;
        end else if (hold_pc) begin
          instr_d = NOP_INSTR;
          ipc_d   = pc_q;
          valid_d = 1'b0;
        end else begin
          instr_d     = imem_data;
          ipc_d       = pc_q;
          valid_d     = 1'b1;
          pc_d        = pc_q + ADDR_W'(1);
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          if (fetch_op == HALT_OP) begin
            state_d = StHalt;
          end
        end
      end

      StHalt: begin
        // The HALT instruction may still be held in IF/ID; drain it once
        // the hold drops, then keep feeding bubbles.
        if (!(hold_if_id && valid_q)) begin
          instr_d = NOP_INSTR;
          ipc_d   = pc_q;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StBoot;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_INSTR;
      ipc_q       <= '0;
      valid_q     <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      ipc_q       <= ipc_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    imem_addr   = pc_q;
    if_id_instr = instr_q;
    if_id_pc    = ipc_q;
    if_id_valid = valid_q;
    halted      = (state_q == StHalt);
    fetch_count = fetch_cnt_q;
    stall_count = stall_cnt_q;
  end

endmodule
